// File: rtl/mult_seq_control.sv
// Sequencer for a shift-and-add multiplier built on one WxW partial-product
// multiplier: walks every (a digit, b digit) pair, one pair per clock.
module mult_seq_control #(
   parameter  int A_DIGITS = 2,
   parameter  int B_DIGITS = 2,
   localparam int A_SEL_W  = (A_DIGITS > 1) ? $clog2(A_DIGITS) : 1,
   localparam int B_SEL_W  = (B_DIGITS > 1) ? $clog2(B_DIGITS) : 1,
   localparam int SHIFT_W  = (A_DIGITS + B_DIGITS - 1 > 1) ?
                             $clog2(A_DIGITS + B_DIGITS - 1) : 1
) (
   input  logic               clk,
   input  logic               reset_a,
   input  logic               start,
   input  logic               abort,
   output logic [A_SEL_W-1:0] a_sel,
   output logic [B_SEL_W-1:0] b_sel,
   output logic [SHIFT_W-1:0] shift_sel,
   output logic               clk_ena,
   output logic               sclr_n,
   output logic               busy,
   output logic               done,
   output logic               err
);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE,
      ERR
   } state_t;

   localparam logic [A_SEL_W-1:0] A_LAST = A_SEL_W'(A_DIGITS - 1);
   localparam logic [B_SEL_W-1:0] B_LAST = B_SEL_W'(B_DIGITS - 1);

   state_t             state;
   logic [A_SEL_W-1:0] a_idx;
   logic [B_SEL_W-1:0] b_idx;
   logic               accept;

   assign accept = start && !abort;

   always_ff @(posedge clk or posedge reset_a) begin
      if (reset_a) begin
         state <= IDLE;
         a_idx <= '0;
         b_idx <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  state <= CALC;
                  a_idx <= '0;
                  b_idx <= '0;
               end
            end
            CALC: begin
               if (abort) begin
                  state <= IDLE;
                  a_idx <= '0;
                  b_idx <= '0;
               end else if (start) begin
                  state <= ERR;
               end else if (a_idx == A_LAST) begin
                  a_idx <= '0;
                  if (b_idx == B_LAST) begin
                     b_idx <= '0;
                     state <= DONE;
                  end else begin
                     b_idx <= b_idx + 1'b1;
                  end
               end else begin
                  a_idx <= a_idx + 1'b1;
               end
            end
            DONE, ERR: begin
               // DONE falls back to IDLE on its own; ERR waits for the host
               if (abort) begin
                  state <= IDLE;
               end else if (start) begin
                  state <= CALC;
               end else if (state == DONE) begin
                  state <= IDLE;
               end
               a_idx <= '0;
               b_idx <= '0;
            end
            default: begin
               state <= IDLE;
               a_idx <= '0;
               b_idx <= '0;
            end
         endcase
      end
   end

   // Outputs follow start/abort in the same cycle, so they are decoded here
   always_comb begin
      a_sel     = '0;
      b_sel     = '0;
      shift_sel = '0;
      clk_ena   = 1'b0;
      sclr_n    = 1'b1;
      busy      = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      if (!reset_a) begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  clk_ena = 1'b1;
                  sclr_n  = 1'b0;
               end
            end
            CALC: begin
               busy = 1'b1;
               if (!abort && !start) begin
                  clk_ena   = 1'b1;
                  a_sel     = a_idx;
                  b_sel     = b_idx;
                  shift_sel = SHIFT_W'(a_idx) + SHIFT_W'(b_idx);
               end
            end
            DONE: begin
               done = 1'b1;
               if (accept) begin
                  clk_ena = 1'b1;
                  sclr_n  = 1'b0;
               end
            end
            ERR: begin
               err = 1'b1;
               if (accept) begin
                  clk_ena = 1'b1;
                  sclr_n  = 1'b0;
               end
            end
            default: begin
               clk_ena = 1'b0;
            end
         endcase
      end
   end

endmodule
